// File: rtl/imu_tilt_joystick_if.sv
// Bus between the tilt-joystick block and its controller/IMU side.
// The master side drives control and IMU data; the slave side is the joystick block.
interface imu_tilt_joystick_if;
  logic               en;
  logic               cal_start;
  logic               imu_req;
  logic               imu_ack;
  logic signed [31:0] roll;
  logic signed [31:0] pitch;
  logic signed [31:0] roll_rel;
  logic signed [31:0] pitch_rel;
  logic               key_left;
  logic               key_right;
  logic               key_up;
  logic               key_down;
  logic               sample_valid;
  logic               cal_busy;
  logic               timeout_err;

  modport master (
    output en, cal_start, imu_ack, roll, pitch,
    input  imu_req, roll_rel, pitch_rel, key_left, key_right, key_up, key_down,
           sample_valid, cal_busy, timeout_err
  );

  modport slave (
    input  en, cal_start, imu_ack, roll, pitch,
    output imu_req, roll_rel, pitch_rel, key_left, key_right, key_up, key_down,
           sample_valid, cal_busy, timeout_err
  );
endinterface

// File: rtl/imu_tilt_joystick.sv
// Polls the IMU for roll/pitch, removes a calibrated zero offset and turns tilt
// beyond a dead zone into four direction keys; includes averaging calibration and ack timeout.
module imu_tilt_joystick #(
  parameter int POLL_PERIOD = 1_000_000,
  parameter int ACK_TIMEOUT = 4_000_000,
  parameter int DEAD_ZONE   = 327680,
  parameter int CAL_LOG2    = 4
) (
  input logic                clk,
  input logic                rst,
  imu_tilt_joystick_if.slave bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_REQ  = 2'd2;
  localparam logic [1:0] S_PROC = 2'd3;

  localparam int CNT_MAX = (POLL_PERIOD > ACK_TIMEOUT) ? POLL_PERIOD : ACK_TIMEOUT;
  localparam int CNT_W   = $clog2(CNT_MAX);
  localparam int SUM_W   = 32 + CAL_LOG2;
  localparam int CAL_N   = 1 << CAL_LOG2;
  localparam int CAL_CW  = CAL_LOG2 + 1;

  localparam logic [CNT_W-1:0]  POLL_LAST = CNT_W'(POLL_PERIOD - 1);
  localparam logic [CNT_W-1:0]  ACK_LAST  = CNT_W'(ACK_TIMEOUT - 1);
  localparam logic [CAL_CW-1:0] CAL_LAST  = CAL_CW'(CAL_N - 1);
  localparam logic signed [31:0] DZ_POS   = 32'(DEAD_ZONE);
  localparam logic signed [31:0] DZ_NEG   = -DZ_POS;

  logic [1:0]               state;
  logic [CNT_W-1:0]         cnt;
  logic signed [31:0]       roll_cap, pitch_cap;
  logic signed [31:0]       roll_off, pitch_off;
  logic signed [SUM_W-1:0]  roll_sum, pitch_sum;
  logic [CAL_CW-1:0]        cal_cnt;
  logic signed [31:0]       roll_rel_q, pitch_rel_q;
  logic                     key_left_q, key_right_q, key_up_q, key_down_q;
  logic                     sample_valid_q, cal_busy_q, timeout_err_q;

  // Difference formed in 33 bits so the true result is exact before clamping.
  function automatic logic signed [31:0] sat_sub(input logic signed [31:0] a,
                                                 input logic signed [31:0] b);
    logic signed [32:0] d;
    d = {a[31], a} - {b[31], b};
    if (d[32] != d[31]) sat_sub = d[32] ? 32'sh8000_0000 : 32'sh7FFF_FFFF;
    else                sat_sub = d[31:0];
  endfunction

  logic signed [31:0]      roll_d, pitch_d;
  logic signed [SUM_W-1:0] roll_sum_nx, pitch_sum_nx;

  assign roll_d       = sat_sub(roll_cap, roll_off);
  assign pitch_d      = sat_sub(pitch_cap, pitch_off);
  assign roll_sum_nx  = roll_sum + SUM_W'(roll_cap);
  assign pitch_sum_nx = pitch_sum + SUM_W'(pitch_cap);

  // NOTE: every piece of state here, offsets and sums included, is plain flops and
  // is cleared by the async reset; there is no memory array that would need to stay unreset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= S_IDLE;
      cnt            <= '0;
      roll_cap       <= '0;
      pitch_cap      <= '0;
      roll_off       <= '0;
      pitch_off      <= '0;
      roll_sum       <= '0;
      pitch_sum      <= '0;
      cal_cnt        <= '0;
      roll_rel_q     <= '0;
      pitch_rel_q    <= '0;
      key_left_q     <= 1'b0;
      key_right_q    <= 1'b0;
      key_up_q       <= 1'b0;
      key_down_q     <= 1'b0;
      sample_valid_q <= 1'b0;
      cal_busy_q     <= 1'b0;
      timeout_err_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments throughout; later assignments in this block
      // (the cal_start clause) deliberately override earlier ones in the same cycle.
      sample_valid_q <= 1'b0;
      case (state)
        S_IDLE: begin
          cnt <= '0;
          if (bus.en) state <= S_WAIT;
        end
        S_WAIT: begin
          if (!bus.en) begin
            state       <= S_IDLE;
            cnt         <= '0;
            roll_rel_q  <= '0;
            pitch_rel_q <= '0;
            key_left_q  <= 1'b0;
            key_right_q <= 1'b0;
            key_up_q    <= 1'b0;
            key_down_q  <= 1'b0;
          end else if (cnt == POLL_LAST) begin
            state <= S_REQ;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_REQ: begin
          if (bus.imu_ack) begin
            roll_cap  <= bus.roll;
            pitch_cap <= bus.pitch;
            state     <= S_PROC;
            cnt       <= '0;
          end else if (cnt == ACK_LAST) begin
            timeout_err_q <= 1'b1;
            key_left_q    <= 1'b0;
            key_right_q   <= 1'b0;
            key_up_q      <= 1'b0;
            key_down_q    <= 1'b0;
            state         <= S_WAIT;
            cnt           <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_PROC: begin
          state <= S_WAIT;
          cnt   <= '0;
          if (!bus.cal_start) begin
            if (cal_busy_q) begin
              if (cal_cnt == CAL_LAST) begin
                // Top 32 bits of the final sum are the arithmetic-shifted average.
                roll_off   <= roll_sum_nx[SUM_W-1:CAL_LOG2];
                pitch_off  <= pitch_sum_nx[SUM_W-1:CAL_LOG2];
                cal_busy_q <= 1'b0;
              end else begin
                roll_sum  <= roll_sum_nx;
                pitch_sum <= pitch_sum_nx;
                cal_cnt   <= cal_cnt + 1'b1;
              end
            end else begin
              roll_rel_q     <= roll_d;
              pitch_rel_q    <= pitch_d;
              key_left_q     <= roll_d < DZ_NEG;
              key_right_q    <= roll_d > DZ_POS;
              key_up_q       <= pitch_d < DZ_NEG;
              key_down_q     <= pitch_d > DZ_POS;
              sample_valid_q <= 1'b1;
            end
          end
        end
        default: state <= S_IDLE;
      endcase

      if (bus.cal_start) begin
        roll_sum      <= '0;
        pitch_sum     <= '0;
        cal_cnt       <= '0;
        timeout_err_q <= 1'b0;
        cal_busy_q    <= 1'b1;
        key_left_q    <= 1'b0;
        key_right_q   <= 1'b0;
        key_up_q      <= 1'b0;
        key_down_q    <= 1'b0;
      end
    end
  end

  assign bus.imu_req      = (state == S_REQ);
  assign bus.roll_rel     = roll_rel_q;
  assign bus.pitch_rel    = pitch_rel_q;
  assign bus.key_left     = key_left_q;
  assign bus.key_right    = key_right_q;
  assign bus.key_up       = key_up_q;
  assign bus.key_down     = key_down_q;
  assign bus.sample_valid = sample_valid_q;
  assign bus.cal_busy     = cal_busy_q;
  assign bus.timeout_err  = timeout_err_q;

endmodule

// File: tb/tb_imu_tilt_joystick.sv
// Scoreboard bench for imu_tilt_joystick: an IMU responder issues samples, a reference
// model predicts each key/offset result, and a monitor compares on every sample_valid.
module tb_imu_tilt_joystick;
  localparam int POLL = 8;
  localparam int ACKT = 20;
  localparam int DZ   = 327680;
  localparam int CALN = 4;
  localparam longint MAXV = 64'sd2147483647;
  localparam longint MINV = -64'sd2147483648;

  logic clk = 1'b0;
  logic rst = 1'b1;
  imu_tilt_joystick_if bus();

  imu_tilt_joystick #(
    .POLL_PERIOD(POLL), .ACK_TIMEOUT(ACKT), .DEAD_ZONE(DZ), .CAL_LOG2(2)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    longint rr;
    longint pr;
    bit     l, r, u, d;
    int     cyc;
  } exp_t;

  exp_t   sb_q[$];
  int     errors = 0;
  int     checks = 0;
  int     cyc    = 0;

  // Reference model state
  longint off_r = 0, off_p = 0, sum_r = 0, sum_p = 0;
  bit     cal_act = 1'b0;
  int     cal_n = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic signed [63:0] act,
                       input logic signed [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic longint sat(input longint d);
    if (d > MAXV) return MAXV;
    if (d < MINV) return MINV;
    return d;
  endfunction

  function automatic longint floor_div(input longint s, input longint n);
    longint q;
    q = s / n;
    if ((s % n != 0) && (s < 0)) q = q - 1;
    return q;
  endfunction

  // Model of one acknowledged sample; valid_cyc is the cycle the result must appear.
  task automatic model_sample(input longint r, input longint p, input int valid_cyc);
    exp_t e;
    if (cal_act) begin
      sum_r += r;
      sum_p += p;
      cal_n++;
      if (cal_n == CALN) begin
        off_r   = floor_div(sum_r, CALN);
        off_p   = floor_div(sum_p, CALN);
        cal_act = 1'b0;
      end
    end else begin
      e.rr  = sat(r - off_r);
      e.pr  = sat(p - off_p);
      e.l   = e.rr < -DZ;
      e.r   = e.rr > DZ;
      e.u   = e.pr < -DZ;
      e.d   = e.pr > DZ;
      e.cyc = valid_cyc;
      sb_q.push_back(e);
    end
  endtask

  exp_t me;
  always @(negedge clk) begin
    if (!rst && bus.sample_valid === 1'b1) begin
      if (sb_q.size() == 0) begin
        check("unexpected_valid", 1, 0);
      end else begin
        me = sb_q.pop_front();
        check("roll_rel", $signed(bus.roll_rel), me.rr);
        check("pitch_rel", $signed(bus.pitch_rel), me.pr);
        check("key_left", bus.key_left, me.l);
        check("key_right", bus.key_right, me.r);
        check("key_up", bus.key_up, me.u);
        check("key_down", bus.key_down, me.d);
        check("valid_cycle", cyc, me.cyc);
      end
    end
  end

  task automatic wait_req(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (bus.imu_req) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) check("req_wait_bound", 0, 1);
  endtask

  task automatic do_txn(input longint r, input longint p, input int dly);
    bit ok;
    wait_req(ok);
    if (ok) begin
      repeat (dly) @(negedge clk);
      bus.roll    = r[31:0];
      bus.pitch   = p[31:0];
      bus.imu_ack = 1'b1;
      @(negedge clk);
      bus.imu_ack = 1'b0;
      bus.roll    = $urandom();
      bus.pitch   = $urandom();
      model_sample(r, p, cyc + 1);
    end
  endtask

  task automatic pulse_cal();
    repeat (2) @(negedge clk);
    bus.cal_start = 1'b1;
    @(negedge clk);
    bus.cal_start = 1'b0;
    cal_act = 1'b1;
    cal_n   = 0;
    sum_r   = 0;
    sum_p   = 0;
    check("cal_busy_set", bus.cal_busy, 1);
    check("cal_clears_timeout", bus.timeout_err, 0);
    check("cal_keys_zero", {bus.key_left, bus.key_right, bus.key_up, bus.key_down}, 0);
  endtask

  function automatic longint rand_angle(input longint base);
    int t;
    t = $urandom();
    case ($urandom_range(0, 2))
      0:       return longint'(t);
      1:       return base + DZ + $urandom_range(0, 4) - 2;
      default: return base - DZ + $urandom_range(0, 4) - 2;
    endcase
  endfunction

  initial begin
    int  n;
    bit  ok;
    bit  seen;
    bus.en        = 1'b0;
    bus.cal_start = 1'b0;
    bus.imu_ack   = 1'b0;
    bus.roll      = '0;
    bus.pitch     = '0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_req", bus.imu_req, 0);
    check("rst_rel", {bus.roll_rel, bus.pitch_rel}, 0);
    check("rst_flags", {bus.key_left, bus.key_right, bus.key_up, bus.key_down,
                        bus.sample_valid, bus.cal_busy, bus.timeout_err}, 0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("idle_no_req", bus.imu_req, 0);

    // Poll timing and a basic right tilt
    bus.en = 1'b1;
    n = 0;
    for (int i = 1; i <= 50; i++) begin
      @(negedge clk);
      if (bus.imu_req) begin
        n = i;
        break;
      end
    end
    check("req_rise_delay", n, POLL + 1);
    do_txn(400000, 0, 3);

    // Dead-zone boundaries are strict
    do_txn(-327680, 0, 1);
    do_txn(-327681, 5, 0);
    do_txn(0, 327680, 2);
    do_txn(0, 327681, 0);
    do_txn(327681, -327681, 1);

    // Dropping en in S_WAIT returns to idle and clears outputs
    do_txn(400000, -400000, 0);
    repeat (2) @(negedge clk);
    bus.en = 1'b0;
    @(negedge clk);
    check("en_off_keys", {bus.key_left, bus.key_right, bus.key_up, bus.key_down}, 0);
    check("en_off_rel", {bus.roll_rel, bus.pitch_rel}, 0);
    seen = 1'b0;
    repeat (30) begin
      @(negedge clk);
      if (bus.imu_req) seen = 1'b1;
    end
    check("en_off_no_req", seen, 0);
    bus.en = 1'b1;

    // Ack timeout, then a late ack that must be ignored
    do_txn(-400000, 400000, 0);
    wait_req(ok);
    n = 0;
    while (bus.imu_req && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("req_high_cycles", n, ACKT);
    check("timeout_err_set", bus.timeout_err, 1);
    check("timeout_keys", {bus.key_left, bus.key_right, bus.key_up, bus.key_down}, 0);
    n = 0;
    while (!bus.imu_req && n < 100) begin
      bus.imu_ack = (n == 2);
      bus.roll    = 32'sd900000;
      @(negedge clk);
      n++;
    end
    bus.imu_ack = 1'b0;
    check("req_low_cycles", n, POLL);
    check("timeout_err_sticky", bus.timeout_err, 1);
    do_txn(0, 0, 0);

    // Calibration averaging, including a negative floor-rounded pitch offset
    pulse_cal();
    do_txn(100, -10, 0);
    do_txn(200, -20, 2);
    do_txn(300, -30, 1);
    do_txn(400, -41, 0);
    check("cal_busy_last", bus.cal_busy, 1);
    @(negedge clk);
    check("cal_busy_done", bus.cal_busy, 0);
    check("cal_no_valid", bus.sample_valid, 0);
    do_txn(250, -26, 2);
    do_txn(250 + 327681, -26 - 327681, 0);

    // Saturation with extreme offsets
    pulse_cal();
    repeat (CALN) do_txn(MAXV, MINV, 1);
    do_txn(MINV, MAXV, 0);

    // Randomized traffic with a random calibration
    pulse_cal();
    repeat (CALN) do_txn($urandom_range(0, 400000) - 200000, $urandom_range(0, 400000) - 200000,
                         $urandom_range(0, 5));
    for (int i = 0; i < 16; i++)
      do_txn(rand_angle(off_r), rand_angle(off_p), $urandom_range(0, 5));

    // Asynchronous reset while a request is outstanding
    pulse_cal();
    wait_req(ok);
    repeat (2) @(negedge clk);
    check("pre_rst_req", bus.imu_req, 1);
    rst = 1'b1;
    #1;
    check("async_rst_req", bus.imu_req, 0);
    check("async_rst_cal", bus.cal_busy, 0);
    check("async_rst_keys", {bus.key_left, bus.key_right, bus.key_up, bus.key_down}, 0);
    check("async_rst_rel", {bus.roll_rel, bus.pitch_rel}, 0);
    off_r   = 0;
    off_p   = 0;
    cal_act = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    do_txn(-400000, 0, 1);

    repeat (5) @(negedge clk);
    check("scoreboard_drained", sb_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "global timeout");
  end
endmodule
